// File: rtl/gpio_padctl.sv
// gpio_padctl: per-pin GPIO pad controller.
//  - Registered output enable and data, with a one-cycle dead period on every
//    direction change so a pad is never driven while its direction settles.
//  - OUT_MASK permanently disables the driver of protected pins.
//  - Two-flop synchroniser on every pad, optional glitch filter, edge
//    detection and sticky per-pin event flags feeding a single irq.
// Build option: define GPIO_PADCTL_FILT_EN to include the glitch filter
// (FILT_CYCLES consecutive differing samples before gpio_i follows the pad).
// Without it gpio_i is the synchroniser output and FILT_CYCLES is unused.
// IOR_DIR_OUT selects the gpio_dir value meaning "output" (default 1).

`ifndef IOR_DIR_OUT
`define IOR_DIR_OUT 1'b1
`endif

module gpio_padctl #(
  parameter int               WIDTH       = 4,
  parameter int               FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0] OUT_MASK    = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpio_dir,
  input  logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_rise,
  output logic [WIDTH-1:0] gpio_fall,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] evt_pend,
  output logic             irq,
  inout  wire  [WIDTH-1:0] pad_gpio
);

  // Reject out-of-range configurations at elaboration time.
  if (WIDTH < 1 || WIDTH > 32 || FILT_CYCLES < 2 || FILT_CYCLES > 256) begin : g_param_check
    $error("gpio_padctl: WIDTH must be 1..32 and FILT_CYCLES 2..256");
  end

  logic [WIDTH-1:0] oe_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] dir_prev;
  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] gpio_i_d;

  // Output register: enable only when the pin has asked for output on two
  // consecutive cycles, so any direction change first passes a high-Z cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_q     <= '0;
      out_q    <= '0;
      dir_prev <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        oe_q[i] <= (gpio_dir[i] == `IOR_DIR_OUT) && (gpio_dir[i] == dir_prev[i]) && OUT_MASK[i];
      end
      out_q    <= gpio_o;
      dir_prev <= gpio_dir;
    end
  end

  // Per-pin tristate pad driver.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pad
    assign pad_gpio[gi] = oe_q[gi] ? out_q[gi] : 1'bz;
  end

  // Two-flop synchroniser on the resolved pad value (includes our own drive).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pad_gpio;
      s2 <= s1;
    end
  end

`ifdef GPIO_PADCTL_FILT_EN
  localparam int             CW      = $clog2(FILT_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_CYCLES - 1);

  logic [WIDTH-1:0] filt;
  logic [CW-1:0]    cnt [WIDTH];

  // Glitch filter: count consecutive samples that differ from the filtered
  // value; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else begin
          filt[i] <= s2[i];
          cnt[i]  <= '0;
        end
      end
    end
  end

  assign gpio_i = filt;
`else
  assign gpio_i = s2;
`endif

  // Delayed copy of gpio_i for edge detection.
  always_ff @(posedge clk) begin
    if (rst) gpio_i_d <= '0;
    else     gpio_i_d <= gpio_i;
  end

  assign gpio_rise = gpio_i & ~gpio_i_d;
  assign gpio_fall = ~gpio_i & gpio_i_d;

  // Sticky event flags: a new enabled edge wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) evt_pend <= '0;
    else     evt_pend <= (evt_pend & ~evt_clr) | (gpio_rise & rise_en) | (gpio_fall & fall_en);
  end

  assign irq = |evt_pend;

endmodule

// File: tb/tb_gpio_padctl.sv
// Directed testbench for gpio_padctl (WIDTH=4, FILT_CYCLES=4, OUT_MASK=4'b1110).
// Pads carry pulldowns, so an undriven pad reads 0.
module tb_gpio_padctl;

  localparam int         WIDTH       = 4;
  localparam int         FILT_CYCLES = 4;
  localparam logic [3:0] OUT_MASK    = 4'b1110;
`ifdef GPIO_PADCTL_FILT_EN
  localparam int LAT = FILT_CYCLES + 1;
  localparam int PRE = 4;
`else
  localparam int LAT = 1;
  localparam int PRE = 1;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] gpio_dir;
  logic [3:0] gpio_o;
  logic [3:0] gpio_i;
  logic [3:0] gpio_rise;
  logic [3:0] gpio_fall;
  logic [3:0] rise_en;
  logic [3:0] fall_en;
  logic [3:0] evt_clr;
  logic [3:0] evt_pend;
  logic       irq;
  wire  [3:0] pad_gpio;
  logic [3:0] tb_oe;
  logic [3:0] tb_val;

  int checks = 0;
  int errors = 0;

  gpio_padctl #(
    .WIDTH       (WIDTH),
    .FILT_CYCLES (FILT_CYCLES),
    .OUT_MASK    (OUT_MASK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gpio_dir  (gpio_dir),
    .gpio_o    (gpio_o),
    .gpio_i    (gpio_i),
    .gpio_rise (gpio_rise),
    .gpio_fall (gpio_fall),
    .rise_en   (rise_en),
    .fall_en   (fall_en),
    .evt_clr   (evt_clr),
    .evt_pend  (evt_pend),
    .irq       (irq),
    .pad_gpio  (pad_gpio)
  );

  // External pad drivers and pulldowns
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ext
    assign pad_gpio[gi] = tb_oe[gi] ? tb_val[gi] : 1'bz;
    pulldown pd (pad_gpio[gi]);
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; gpio_dir = 4'b1111; gpio_o = 4'b1111;
    rise_en = 4'b0; fall_en = 4'b0; evt_clr = 4'b0;
    tb_oe = 4'b0; tb_val = 4'b0;
    step(); step();
    checks++; if (pad_gpio !== 4'b0000) begin errors++; $display("FAIL reset_pad: got %b expected 0000", pad_gpio); end
    checks++; if (gpio_i !== 4'b0000) begin errors++; $display("FAIL reset_gpio_i: got %b expected 0000", gpio_i); end
    checks++; if ({gpio_rise, gpio_fall} !== 8'h00) begin errors++; $display("FAIL reset_edges: got %b expected 00000000", {gpio_rise, gpio_fall}); end
    checks++; if ({evt_pend, irq} !== 5'b0) begin errors++; $display("FAIL reset_pend_irq: got %b expected 00000", {evt_pend, irq}); end
  endtask

  task automatic test_out_mask();
    rst = 1'b0;
    step();
    checks++; if (pad_gpio !== 4'b0000) begin errors++; $display("FAIL mask_dead_cycle: got %b expected 0000", pad_gpio); end
    step();
    checks++; if (pad_gpio !== 4'b1110) begin errors++; $display("FAIL mask_drive: got %b expected 1110", pad_gpio); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (pad_gpio[0] !== 1'b0) begin errors++; $display("FAIL mask_bit0 cycle %0d: got %b expected 0", c, pad_gpio[0]); end
    end
    gpio_o = 4'b1010;
    step();
    checks++; if (pad_gpio !== 4'b1010) begin errors++; $display("FAIL out_latency_a: got %b expected 1010", pad_gpio); end
    gpio_o = 4'b0101;
    step();
    checks++; if (pad_gpio !== 4'b0100) begin errors++; $display("FAIL out_latency_b: got %b expected 0100", pad_gpio); end
  endtask

  task automatic test_dir_switch();
    gpio_o = 4'b0010;
    step();
    checks++; if (pad_gpio !== 4'b0010) begin errors++; $display("FAIL dir_pin1_out: got %b expected 0010", pad_gpio); end
    gpio_dir = 4'b1101;
    step();
    checks++; if (pad_gpio !== 4'b0000) begin errors++; $display("FAIL dir_to_in_n: got %b expected 0000", pad_gpio); end
    step();
    checks++; if (pad_gpio !== 4'b0000) begin errors++; $display("FAIL dir_in_hold: got %b expected 0000", pad_gpio); end
    gpio_dir = 4'b1111;
    step();
    checks++; if (pad_gpio !== 4'b0000) begin errors++; $display("FAIL dir_to_out_m: got %b expected 0000", pad_gpio); end
    step();
    checks++; if (pad_gpio !== 4'b0010) begin errors++; $display("FAIL dir_to_out_m1: got %b expected 0010", pad_gpio); end
  endtask

  task automatic test_input_path();
    gpio_dir = 4'b0000; gpio_o = 4'b0000;
    step();
    tb_oe = 4'b1111; tb_val = 4'b0000;
    repeat (LAT + 4) step();
    evt_clr = 4'b1111;
    step();
    evt_clr = 4'b0000; rise_en = 4'b0100; fall_en = 4'b0000;
    checks++; if ({evt_pend, irq} !== 5'b0) begin errors++; $display("FAIL in_idle_pend: got %b expected 00000", {evt_pend, irq}); end
    tb_val[2] = 1'b1;
    step();
    checks++; if (gpio_i !== 4'b0000) begin errors++; $display("FAIL in_rise_early: got %b expected 0000", gpio_i); end
    for (int c = 0; c < LAT - 1; c++) begin
      step();
      checks++; if (gpio_i !== 4'b0000) begin errors++; $display("FAIL in_rise_wait %0d: got %b expected 0000", c, gpio_i); end
    end
    step();
    checks++; if (gpio_i !== 4'b0100) begin errors++; $display("FAIL in_rise_gpio_i: got %b expected 0100", gpio_i); end
    checks++; if ({gpio_rise, evt_pend} !== 8'b0100_0000) begin errors++; $display("FAIL in_rise_pulse: got %b expected 01000000", {gpio_rise, evt_pend}); end
    step();
    checks++; if ({gpio_rise, evt_pend, irq} !== 9'b0000_0100_1) begin errors++; $display("FAIL in_rise_pend: got %b expected 000001001", {gpio_rise, evt_pend, irq}); end
    tb_val[2] = 1'b0;
    repeat (LAT) step();
    step();
    checks++; if ({gpio_fall, gpio_rise} !== 8'b0100_0000) begin errors++; $display("FAIL in_fall_pulse: got %b expected 01000000", {gpio_fall, gpio_rise}); end
    step();
    checks++; if ({gpio_fall, evt_pend} !== 8'b0000_0100) begin errors++; $display("FAIL in_fall_disabled: got %b expected 00000100", {gpio_fall, evt_pend}); end
    evt_clr = 4'b0100;
    step();
    evt_clr = 4'b0000;
    checks++; if ({evt_pend, irq} !== 5'b0) begin errors++; $display("FAIL in_clear: got %b expected 00000", {evt_pend, irq}); end
  endtask

  task automatic test_set_wins();
    tb_val[2] = 1'b1;
    repeat (LAT + 2) step();
    tb_val[2] = 1'b0;
    repeat (LAT + 2) step();
    checks++; if ({gpio_i, evt_pend} !== 8'b0000_0100) begin errors++; $display("FAIL sw_setup: got %b expected 00000100", {gpio_i, evt_pend}); end
    tb_val[2] = 1'b1;
    repeat (LAT + 1) step();
    checks++; if ({gpio_rise, evt_pend} !== 8'b0100_0100) begin errors++; $display("FAIL sw_rise: got %b expected 01000100", {gpio_rise, evt_pend}); end
    evt_clr = 4'b0100;
    step();
    checks++; if ({evt_pend, irq} !== 5'b0100_1) begin errors++; $display("FAIL sw_set_wins: got %b expected 01001", {evt_pend, irq}); end
    step();
    evt_clr = 4'b0000;
    checks++; if ({evt_pend, irq} !== 5'b0) begin errors++; $display("FAIL sw_clear_alone: got %b expected 00000", {evt_pend, irq}); end
  endtask

`ifdef GPIO_PADCTL_FILT_EN
  task automatic test_glitch();
    tb_val[2] = 1'b0;
    repeat (LAT + 3) step();
    evt_clr = 4'b1111;
    step();
    evt_clr = 4'b0000;
    tb_val[2] = 1'b1;
    repeat (3) step();
    tb_val[2] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if ({gpio_i, gpio_rise, evt_pend} !== 12'h000) begin errors++; $display("FAIL glitch3 cycle %0d: got %b expected 0", c, {gpio_i, gpio_rise, evt_pend}); end
    end
    tb_val[2] = 1'b1;
    repeat (4) step();
    tb_val[2] = 1'b0;
    step();
    checks++; if (gpio_i !== 4'b0000) begin errors++; $display("FAIL pulse4_k4: got %b expected 0000", gpio_i); end
    step();
    checks++; if ({gpio_i, gpio_rise} !== 8'b0100_0100) begin errors++; $display("FAIL pulse4_k5: got %b expected 01000100", {gpio_i, gpio_rise}); end
    step();
    checks++; if ({gpio_rise, evt_pend} !== 8'b0000_0100) begin errors++; $display("FAIL pulse4_pend: got %b expected 00000100", {gpio_rise, evt_pend}); end
    repeat (LAT + 3) step();
    evt_clr = 4'b1111;
    step();
    evt_clr = 4'b0000;
  endtask
`endif

  task automatic test_reset_mid();
    tb_val[2] = 1'b0;
    repeat (LAT + 3) step();
    evt_clr = 4'b1111;
    step();
    evt_clr = 4'b0000;
    tb_val[2] = 1'b1;
    repeat (PRE) step();
    checks++; if (gpio_i !== 4'b0000) begin errors++; $display("FAIL rm_before_reset: got %b expected 0000", gpio_i); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({gpio_i, evt_pend, irq} !== 9'b0) begin errors++; $display("FAIL rm_in_reset: got %b expected 0", {gpio_i, evt_pend, irq}); end
    step();
    checks++; if (gpio_i !== 4'b0000) begin errors++; $display("FAIL rm_first_edge: got %b expected 0000", gpio_i); end
    for (int c = 0; c < LAT - 1; c++) begin
      step();
      checks++; if (gpio_i !== 4'b0000) begin errors++; $display("FAIL rm_wait %0d: got %b expected 0000", c, gpio_i); end
    end
    step();
    checks++; if ({gpio_i, gpio_rise} !== 8'b0100_0100) begin errors++; $display("FAIL rm_rise: got %b expected 01000100", {gpio_i, gpio_rise}); end
    step();
    checks++; if ({gpio_rise, evt_pend, irq} !== 9'b0000_0100_1) begin errors++; $display("FAIL rm_pend: got %b expected 000001001", {gpio_rise, evt_pend, irq}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_out_mask();
    test_dir_switch();
    test_input_path();
    test_set_wins();
`ifdef GPIO_PADCTL_FILT_EN
    test_glitch();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_padctl.md
GPIO_PADCTL -- requirements
Module: gpio_padctl

Interface
REQ-001 Parameter WIDTH, default 4, number of GPIO pins (1..32).
REQ-002 Parameter FILT_CYCLES, default 4, consecutive stable samples needed before the filtered input changes (2..256).
REQ-003 Parameter OUT_MASK, WIDTH bits, default all ones; a pin with its bit 0 is never driven (board protection).
REQ-004 Port list, clock and reset first:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- gpio_dir  in  WIDTH  per-pin direction; `IOR_DIR_OUT = output, any other value = input.
- gpio_o  in  WIDTH  output data.
- gpio_i  out  WIDTH  synchronised, filtered input.
- gpio_rise  out  WIDTH  one-cycle pulse on a gpio_i 0->1 transition.
- gpio_fall  out  WIDTH  one-cycle pulse on a gpio_i 1->0 transition.
- rise_en  in  WIDTH  rise-event enable.
- fall_en  in  WIDTH  fall-event enable.
- evt_clr  in  WIDTH  clear pending event, one bit per pin.
- evt_pend  out  WIDTH  sticky pending-event flags.
- irq  out  1  OR of evt_pend.
- pad_gpio  inout  WIDTH  pads.

Function
REQ-005 Output path: oe_q[i] and out_q[i] are registered; pad_gpio[i] = out_q[i] when oe_q[i]=1, else high-Z.
REQ-006 oe_q[i] loads (gpio_dir[i]==`IOR_DIR_OUT) AND (gpio_dir[i]==dir_prev[i]) AND OUT_MASK[i]; dir_prev loads gpio_dir every cycle.
REQ-007 Direction change at edge n: oe_q=0 after edge n (dead cycle); a change to output drives the pad from edge n+1.
REQ-008 Steady-state output latency: gpio_o to pad is 1 cycle.
REQ-009 Input path: 2-flop synchroniser per pin (s1, s2) samples pad_gpio, including the pin's own driven value.
REQ-010 Filter per pin, counter width $clog2(FILT_CYCLES):
- s2==filt: cnt<=0.
- s2!=filt and cnt<FILT_CYCLES-1: cnt<=cnt+1.
- s2!=filt and cnt==FILT_CYCLES-1: filt<=s2, cnt<=0.
REQ-011 Any sample where s2==filt restarts the count; glitches shorter than FILT_CYCLES cycles never reach gpio_i.
REQ-012 gpio_i=filt; pad change before edge k appears on gpio_i after edge k+1+FILT_CYCLES.
REQ-013 gpio_rise = gpio_i & ~gpio_i_d and gpio_fall = ~gpio_i & gpio_i_d, where gpio_i_d is gpio_i delayed one cycle; each pulse lasts exactly 1 cycle.
REQ-014 evt_pend[i] sets on (gpio_rise[i]&rise_en[i]) | (gpio_fall[i]&fall_en[i]), visible the next cycle.
REQ-015 evt_clr[i] clears evt_pend[i] next cycle; a simultaneous set and clear leaves the flag set (set wins).
REQ-016 irq = |evt_pend, combinational from registers.
REQ-017 Pins are fully independent; no cross-pin state.

Reset
REQ-018 While rst=1 at an edge: oe_q, out_q, dir_prev, s1, s2, filt, gpio_i_d, cnt and evt_pend go to 0; pads high-Z; irq=0; gpio_rise=gpio_fall=0.
REQ-019 Reset mid-filter discards the partial count; a pad held at 1 through reset yields gpio_rise after the REQ-012 latency and sets evt_pend if rise_en=1.

Configuration
REQ-020 Macro GPIO_PADCTL_FILT_EN:
- Defined: filter per REQ-010..012 is present.
- Undefined: no counters; gpio_i=s2, latency 2 edges; FILT_CYCLES is ignored; all other behaviour unchanged.

Verification
REQ-021 WIDTH=4, OUT_MASK=4'b1110, gpio_dir=all OUT, gpio_o=4'b1111 -> pad_gpio=4'b111Z one cycle later; bit 0 is never driven in any cycle.
REQ-022 Pin 1 OUT then switched to IN at edge n -> high-Z from edge n; switched back to OUT at edge m -> high-Z after edge m, driven after edge m+1.
REQ-023 FILT_EN, FILT_CYCLES=4: pad pulse 3 cycles wide -> gpio_i, gpio_rise and evt_pend stay 0; pulse 4 cycles wide -> gpio_i=1 after edge k+5 and one gpio_rise.
REQ-024 rise_en=1, evt_pend=1, evt_clr=1 in the same cycle as a new gpio_rise -> evt_pend stays 1 and irq stays 1; evt_clr alone -> 0 the next cycle.
REQ-025 rst asserted with cnt=2 on a rising pad -> after release, a full FILT_CYCLES+2 cycles elapse before gpio_i=1.
REQ-026 FILT_EN undefined: pad 0->1 before edge k -> gpio_i=1 after edge k+1; gpio_rise is high for exactly that one cycle.
